priority_resolver: RTL and testbench
====================================

PRIORITY_RESOLVER -- requirements
Module: priority_resolver

Interface
REQ-001 Parameter RESET_BOTTOM_LEVEL, default 7, meaning the IR level holding lowest priority after reset (0..7).
REQ-002 clk  input  1  single block clock, rising-edge active.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 interrupt_req_register  input  8  IRR contents from request stage.
REQ-005 interrupt_mask  input  8  OCW1 mask; 1 = level masked.
REQ-006 vector_base  input  5  ICW2 bits T7..T3.
REQ-007 inta_n  input  1  interrupt acknowledge, active-low, already synchronous to clk.
REQ-008 eoi_cmd  input  1  one-cycle EOI command strobe.
REQ-009 eoi_specific  input  1  1 = specific EOI, 0 = non-specific.
REQ-010 eoi_level  input  3  level for specific EOI.
REQ-011 auto_eoi  input  1  ICW4 AEOI mode.
REQ-012 rotate_en  input  1  rotate-on-EOI mode (used only with macro, see Configuration).
REQ-013 interrupt_out  output  1  INT to CPU.
REQ-014 freeze  output  1  IRR freeze to request stage.
REQ-015 clear_interrupt_req  output  8  one-hot IRR clear pulse.
REQ-016 in_service_register  output  8  ISR.
REQ-017 vector_out  output  8  interrupt vector.
REQ-018 vector_valid  output  1  vector_out qualified.

Function
REQ-019 Priority order SHALL be circular: highest = (bottom_level+1) mod 8, lowest = bottom_level.
REQ-020 Pending set SHALL be interrupt_req_register AND NOT interrupt_mask; winner = highest-priority pending bit.
REQ-021 interrupt_out SHALL be registered, asserted one cycle after a winner exists with priority strictly higher than every ISR bit (fully nested), deasserted when none exists or in ACK1/ACK2.
REQ-022 FSM states IDLE, ACK1, ACK2; inta_n falling edge detected against its registered copy.
REQ-023 IDLE -> ACK1 on inta_n fall: freeze=1; winner latched; ISR[winner] set; clear_interrupt_req[winner] pulsed exactly one cycle.
REQ-024 No winner at first fall (spurious): latched level=7, ISR unchanged, no clear pulse.
REQ-025 ACK1 -> ACK2 on second inta_n fall: vector_out={vector_base, level}, vector_valid=1 while inta_n low.
REQ-026 ACK2 -> IDLE on inta_n rise: vector_valid=0, freeze=0; if auto_eoi, clear ISR[level] same cycle.
REQ-027 Non-specific EOI SHALL clear highest-priority set ISR bit; specific EOI clears ISR[eoi_level]; EOI with target bit clear or ISR empty SHALL have no effect.
REQ-028 EOI same cycle as ACK1 ISR set: clear evaluates against prior ISR, set applied after; set wins on same bit.
REQ-029 reset_n low in any state SHALL return to IDLE immediately regardless of inta_n.

Reset
REQ-030 On reset: ISR=0, bottom_level=RESET_BOTTOM_LEVEL, state IDLE, interrupt_out=0, freeze=0, clear_interrupt_req=0, vector_out=0, vector_valid=0.

Configuration
REQ-031 Macro PRIORITY_ROTATION_EN defined: when rotate_en=1, each EOI (and AEOI clear) that clears level L SHALL set bottom_level=L next cycle.
REQ-032 Macro undefined: bottom_level fixed at RESET_BOTTOM_LEVEL, rotate_en ignored, no rotation logic compiled.

Structure
REQ-033 Shared package SHALL hold FSM state enum, level type (3-bit), NUM_IR=8, SPURIOUS_LEVEL=7.
REQ-034 One sub-module priority_encoder_rot: combinational circular highest-priority select given vector and bottom_level, instantiated for IRR winner and ISR highest.

Verification
REQ-035 IRR=0x28, mask=0, ISR=0 -> interrupt_out=1 after 1 cycle; two INTA, vector_base=0x08 -> ISR=0x08, clear pulse 0x08, vector_out=0x43.
REQ-036 ISR=0x04, IRR=0x10 -> interrupt_out stays 0; IRR=0x02 -> interrupt_out=1.
REQ-037 INTA with IRR=0 -> vector_out={base,3'd7}, ISR unchanged, no clear pulse.
REQ-038 auto_eoi=1, IRR=0x01 -> ISR bit0 set in ACK1, 0 after inta_n rise.
REQ-039 PRIORITY_ROTATION_EN, rotate_en=1, ISR=0x08, non-specific EOI -> ISR=0, bottom=3; then IRR=0x11 -> winner IR4.
REQ-040 reset_n low during ACK2 -> freeze=0, vector_valid=0, ISR=0 asynchronously.

Source files
------------

// File: rtl/priority_resolver_pkg.sv
// Shared types and helpers for the interrupt priority resolver.
package priority_resolver_pkg;

    localparam int NUM_IR = 8;

    typedef logic [2:0] level_t;

    localparam level_t SPURIOUS_LEVEL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK1 = 2'd1,
        ST_ACK2 = 2'd2
    } state_t;

    function automatic logic [NUM_IR-1:0] level_onehot(input level_t lvl);
        return 8'b1 << lvl;
    endfunction

    // 0 = highest priority, 7 = the bottom level itself.
    function automatic level_t prio_rank(input level_t lvl, input level_t bottom);
        return lvl - bottom - 3'd1;
    endfunction

endpackage

// File: rtl/priority_resolver_encoder_rot.sv
// Circular highest-priority select: level bottom_level+1 wins first, bottom_level last.
module priority_encoder_rot
    import priority_resolver_pkg::*;
(
    input  logic [NUM_IR-1:0] vec,
    input  level_t            bottom_level,
    output logic              found,
    output level_t            level
);

    level_t idx;

    // Walk from lowest to highest priority so the highest set bit is written last.
    always_comb begin
        found = |vec;
        level = '0;
        idx   = '0;
        for (int i = NUM_IR - 1; i >= 0; i--) begin
            idx = bottom_level + level_t'(i) + 3'd1;
            if (vec[idx]) level = idx;
        end
    end

endmodule

// File: rtl/priority_resolver.sv
// Interrupt priority resolver: fully nested priority, two-pulse INTA sequencing, ISR/EOI handling.
// Optional macro PRIORITY_ROTATION_EN enables rotate-on-EOI of the bottom priority level.
module priority_resolver
    import priority_resolver_pkg::*;
#(
    parameter int RESET_BOTTOM_LEVEL = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_IR-1:0] interrupt_req_register,
    input  logic [NUM_IR-1:0] interrupt_mask,
    input  logic [4:0]        vector_base,
    input  logic              inta_n,
    input  logic              eoi_cmd,
    input  logic              eoi_specific,
    input  level_t            eoi_level,
    input  logic              auto_eoi,
    input  logic              rotate_en,
    output logic              interrupt_out,
    output logic              freeze,
    output logic [NUM_IR-1:0] clear_interrupt_req,
    output logic [NUM_IR-1:0] in_service_register,
    output logic [7:0]        vector_out,
    output logic              vector_valid
);

    // state | meaning
    // IDLE  | waiting for first INTA pulse, INT may be raised
    // ACK1  | first INTA seen: winner latched, ISR set, IRR frozen
    // ACK2  | second INTA seen: vector driven until INTA rises

    localparam level_t RESET_BOTTOM = level_t'(RESET_BOTTOM_LEVEL);

    state_t            state, next_state;
    logic              inta_q, inta_fall, inta_rise;
    logic [NUM_IR-1:0] pending;
    level_t            bottom_level;
    logic              winner_found, isr_found;
    level_t            winner_level, isr_level;
    level_t            ack_level;
    logic              ack_real;
    logic              int_req;
    logic              ack_start, ack_vector, ack_end;
    level_t            eoi_target;
    logic              eoi_hit, aeoi_hit;
    logic [NUM_IR-1:0] isr_set, isr_clr, isr_next;

    assign pending   = interrupt_req_register & ~interrupt_mask;
    assign inta_fall = inta_q & ~inta_n;
    assign inta_rise = ~inta_q & inta_n;

    priority_encoder_rot u_irr_enc (
        .vec          (pending),
        .bottom_level (bottom_level),
        .found        (winner_found),
        .level        (winner_level)
    );

    priority_encoder_rot u_isr_enc (
        .vec          (in_service_register),
        .bottom_level (bottom_level),
        .found        (isr_found),
        .level        (isr_level)
    );

    // Fully nested: only a request strictly above the highest in-service level interrupts.
    assign int_req = winner_found &&
                     (!isr_found || (prio_rank(winner_level, bottom_level) <
                                     prio_rank(isr_level, bottom_level)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (inta_fall) next_state = ST_ACK1;
            ST_ACK1: if (inta_fall) next_state = ST_ACK2;
            ST_ACK2: if (inta_rise) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        freeze     = (state != ST_IDLE);
        ack_start  = (state == ST_IDLE) && inta_fall;
        ack_vector = (state == ST_ACK1) && inta_fall;
        ack_end    = (state == ST_ACK2) && inta_rise;
    end

    // EOI clears are judged against the ISR before this cycle's set; the set is OR'd in last.
    always_comb begin
        eoi_target = eoi_specific ? eoi_level : isr_level;
        eoi_hit    = eoi_cmd && in_service_register[eoi_target];
        aeoi_hit   = ack_end && auto_eoi && ack_real;
        isr_clr    = (eoi_hit  ? level_onehot(eoi_target) : '0) |
                     (aeoi_hit ? level_onehot(ack_level)  : '0);
        isr_set    = (ack_start && winner_found) ? level_onehot(winner_level) : '0;
        isr_next   = (in_service_register & ~isr_clr) | isr_set;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inta_q              <= 1'b1;
            in_service_register <= '0;
            interrupt_out       <= 1'b0;
            clear_interrupt_req <= '0;
            ack_level           <= SPURIOUS_LEVEL;
            ack_real            <= 1'b0;
            vector_out          <= '0;
            vector_valid        <= 1'b0;
        end else begin
            inta_q              <= inta_n;
            in_service_register <= isr_next;
            interrupt_out       <= int_req && (next_state == ST_IDLE);
            clear_interrupt_req <= isr_set;
            if (ack_start) begin
                ack_level <= winner_found ? winner_level : SPURIOUS_LEVEL;
                ack_real  <= winner_found;
            end
            if (ack_vector) begin
                vector_out   <= {vector_base, ack_level};
                vector_valid <= 1'b1;
            end else if (ack_end) begin
                vector_valid <= 1'b0;
            end
        end
    end

`ifdef PRIORITY_ROTATION_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bottom_level <= RESET_BOTTOM;
        end else if (rotate_en) begin
            if (eoi_hit)       bottom_level <= eoi_target;
            else if (aeoi_hit) bottom_level <= ack_level;
        end
    end
`else
    logic unused_rotate;
    assign bottom_level  = RESET_BOTTOM;
    assign unused_rotate = rotate_en;
`endif

endmodule

// File: tb/tb_priority_resolver.sv
// Self-checking bench for priority_resolver: vectors scoreboarded, ISR/INT/clear checked inline.
module tb_priority_resolver;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] irr, mask;
    logic [4:0] vector_base;
    logic       inta_n, eoi_cmd, eoi_specific, auto_eoi, rotate_en;
    logic [2:0] eoi_level;
    logic       interrupt_out, freeze, vector_valid;
    logic [7:0] clear_interrupt_req, in_service_register, vector_out;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    logic       vv_prev = 1'b0;

    priority_resolver #(.RESET_BOTTOM_LEVEL(7)) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .interrupt_req_register (irr),
        .interrupt_mask         (mask),
        .vector_base            (vector_base),
        .inta_n                 (inta_n),
        .eoi_cmd                (eoi_cmd),
        .eoi_specific           (eoi_specific),
        .eoi_level              (eoi_level),
        .auto_eoi               (auto_eoi),
        .rotate_en              (rotate_en),
        .interrupt_out          (interrupt_out),
        .freeze                 (freeze),
        .clear_interrupt_req    (clear_interrupt_req),
        .in_service_register    (in_service_register),
        .vector_out             (vector_out),
        .vector_valid           (vector_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Vector scoreboard: one expected vector per rising edge of vector_valid.
    always @(negedge clk) begin
        if (vector_valid && !vv_prev) begin
            check("sb_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("vector_out", vector_out, exp_q.pop_front());
        end
        vv_prev = vector_valid;
    end

    task automatic do_ack(input logic [7:0] e_isr1, input logic [7:0] e_clr,
                          input logic [7:0] e_vec, input logic [7:0] e_isr_end,
                          input logic eoi_now, input logic eoi_spec, input logic [2:0] eoi_lvl);
        inta_n = 1'b0;
        eoi_cmd = eoi_now; eoi_specific = eoi_spec; eoi_level = eoi_lvl;
        tick();
        eoi_cmd = 1'b0;
        check("ack1_freeze", freeze, 1);
        check("ack1_isr", in_service_register, e_isr1);
        check("ack1_clear", clear_interrupt_req, e_clr);
        check("ack1_int", interrupt_out, 0);
        tick();
        check("clear_pulse_len", clear_interrupt_req, 0);
        inta_n = 1'b1;
        tick();
        exp_q.push_back(e_vec);
        inta_n = 1'b0;
        tick();
        check("ack2_valid", vector_valid, 1);
        check("ack2_freeze", freeze, 1);
        inta_n = 1'b1;
        tick();
        check("idle_freeze", freeze, 0);
        check("idle_valid", vector_valid, 0);
        check("end_isr", in_service_register, e_isr_end);
    endtask

    task automatic do_eoi(input logic spec, input logic [2:0] lvl, input logic [7:0] e_isr);
        eoi_cmd = 1'b1; eoi_specific = spec; eoi_level = lvl;
        tick();
        eoi_cmd = 1'b0;
        check("eoi_isr", in_service_register, e_isr);
    endtask

    initial begin
        reset_n = 1'b0; irr = '0; mask = '0; vector_base = 5'h08; inta_n = 1'b1;
        eoi_cmd = 1'b0; eoi_specific = 1'b0; eoi_level = '0; auto_eoi = 1'b0; rotate_en = 1'b0;
        #12;
        check("rst_int", interrupt_out, 0);
        check("rst_freeze", freeze, 0);
        check("rst_clear", clear_interrupt_req, 0);
        check("rst_isr", in_service_register, 0);
        check("rst_vector", vector_out, 0);
        check("rst_valid", vector_valid, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Two requests, IR3 wins over IR5 with bottom level 7.
        irr = 8'h28;
        check("int_pre", interrupt_out, 0);
        tick();
        check("int_one_cycle", interrupt_out, 1);
        do_ack(8'h08, 8'h08, 8'h43, 8'h08, 1'b0, 1'b0, 3'd0);
        irr = 8'h20;
        tick(); tick();
        check("int_lower_blocked", interrupt_out, 0);
        do_eoi(1'b0, 3'd0, 8'h00);
        tick();
        check("int_after_eoi", interrupt_out, 1);
        irr = 8'h00;
        tick();
        check("int_drop", interrupt_out, 0);

        // Nesting against ISR=0x04.
        irr = 8'h04;
        tick();
        do_ack(8'h04, 8'h04, 8'h42, 8'h04, 1'b0, 1'b0, 3'd0);
        irr = 8'h10;
        tick(); tick();
        check("nest_low_blocked", interrupt_out, 0);
        irr = 8'h02;
        tick();
        check("nest_high_int", interrupt_out, 1);
        do_eoi(1'b1, 3'd6, 8'h04);
        do_ack(8'h06, 8'h02, 8'h41, 8'h06, 1'b0, 1'b0, 3'd0);
        irr = 8'h00;
        do_eoi(1'b0, 3'd0, 8'h04);
        do_eoi(1'b1, 3'd2, 8'h00);
        do_eoi(1'b0, 3'd0, 8'h00);

        // EOI coinciding with the ACK1 set.
        irr = 8'h04;
        tick();
        do_ack(8'h04, 8'h04, 8'h42, 8'h04, 1'b0, 1'b0, 3'd0);
        irr = 8'h02;
        tick();
        do_ack(8'h02, 8'h02, 8'h41, 8'h02, 1'b1, 1'b0, 3'd0);
        do_ack(8'h02, 8'h02, 8'h41, 8'h02, 1'b1, 1'b1, 3'd1);
        irr = 8'h00;
        do_eoi(1'b1, 3'd1, 8'h00);

        // Spurious acknowledge and masking.
        vector_base = 5'h10;
        do_ack(8'h00, 8'h00, 8'h87, 8'h00, 1'b0, 1'b0, 3'd0);
        vector_base = 5'h08;
        mask = 8'hFF; irr = 8'hFF;
        tick(); tick();
        check("masked_int", interrupt_out, 0);
        mask = 8'h00; irr = 8'h00;
        tick();

        // Auto-EOI.
        auto_eoi = 1'b1;
        irr = 8'h01;
        tick();
        do_ack(8'h01, 8'h01, 8'h40, 8'h00, 1'b0, 1'b0, 3'd0);
        auto_eoi = 1'b0;
        irr = 8'h00;
        tick();

        // Rotate on EOI (ignored unless built with rotation).
        irr = 8'h08;
        tick();
        do_ack(8'h08, 8'h08, 8'h43, 8'h08, 1'b0, 1'b0, 3'd0);
        irr = 8'h00;
        rotate_en = 1'b1;
        do_eoi(1'b0, 3'd0, 8'h00);
        irr = 8'h11;
        tick();
        check("rot_int", interrupt_out, 1);
`ifdef PRIORITY_ROTATION_EN
        do_ack(8'h10, 8'h10, 8'h44, 8'h10, 1'b0, 1'b0, 3'd0);
`else
        do_ack(8'h01, 8'h01, 8'h40, 8'h01, 1'b0, 1'b0, 3'd0);
`endif
        irr = 8'h00;
        do_eoi(1'b0, 3'd0, 8'h00);
        rotate_en = 1'b0;

        // Asynchronous reset during ACK2.
        irr = 8'h20;
        tick();
        inta_n = 1'b0; tick(); tick();
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        check("pre_rst_valid", vector_valid, 1);
        check("pre_rst_isr", in_service_register, 8'h20);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_freeze", freeze, 0);
        check("async_valid", vector_valid, 0);
        check("async_isr", in_service_register, 0);
        check("async_vector", vector_out, 0);
        inta_n = 1'b1; irr = 8'h00;
        tick();
        reset_n = 1'b1;
        tick(); tick();
        check("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
